// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - shared character classes and ASCII bounds for the identifier blocks
package id_pkg;

  localparam logic [7:0] ASCII_0     = 8'd48;
  localparam logic [7:0] ASCII_9     = 8'd57;
  localparam logic [7:0] ASCII_UC_A  = 8'd65;
  localparam logic [7:0] ASCII_UC_Z  = 8'd90;
  localparam logic [7:0] ASCII_LC_A  = 8'd97;
  localparam logic [7:0] ASCII_LC_Z  = 8'd122;

  // Encoding must stay identical to the identifier FSM's type encoding.
  typedef enum logic [1:0] {
    CLS_OTHER  = 2'b00,
    CLS_LETTER = 2'b01,
    CLS_DIGIT  = 2'b10
  } cls_e;

  function automatic cls_e classify(input logic [7:0] c);
    if ((c >= ASCII_UC_A && c <= ASCII_UC_Z) || (c >= ASCII_LC_A && c <= ASCII_LC_Z))
      return CLS_LETTER;
    else if (c >= ASCII_0 && c <= ASCII_9)
      return CLS_DIGIT;
    else
      return CLS_OTHER;
  endfunction

endpackage

// File: rtl/len_fifo.sv
// rtl/len_fifo.sv - synchronous FIFO holding completed token lengths
module len_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop on the same edge frees the slot a full-FIFO push needs.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

endmodule

// File: rtl/id_token_stat.sv
// rtl/id_token_stat.sv - measures, counts and queues lengths of matched identifiers
module id_token_stat
  import id_pkg::*;
#(
  parameter int CNT_W      = 16,
  parameter int LEN_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       char_i,
  input  logic             id_match,
  input  logic             len_ready,
  output logic             len_valid,
  output logic [LEN_W-1:0] len_data,
  output logic [CNT_W-1:0] id_count,
  output logic [LEN_W-1:0] max_len,
  output logic             overflow
);

  cls_e             cls;
  logic             term;
  logic             fifo_empty, fifo_full, fifo_pop;
  logic [LEN_W-1:0] fifo_dout, tok_len_inc;
  logic [LEN_W-1:0] tok_len_q, tok_len_d;
  logic             in_word_q, in_word_d;
  logic [CNT_W-1:0] id_count_q, id_count_d;
  logic [LEN_W-1:0] max_len_q, max_len_d;
  logic             overflow_q, overflow_d;

  assign cls         = classify(char_i);
  assign term        = id_match && (cls == CLS_OTHER) && (tok_len_q != '0);
  assign tok_len_inc = (tok_len_q == '1) ? tok_len_q : tok_len_q + LEN_W'(1);
  assign fifo_pop    = len_ready && !fifo_empty;

  always_comb begin
    tok_len_d  = tok_len_q;
    in_word_d  = in_word_q;
    id_count_d = id_count_q;
    max_len_d  = max_len_q;
    overflow_d = overflow_q;
    // Digits before the first letter are not part of the token.
    case (cls)
      CLS_OTHER: begin
        in_word_d = 1'b0;
        tok_len_d = '0;
      end
      CLS_LETTER: begin
        in_word_d = 1'b1;
        tok_len_d = tok_len_inc;
      end
      CLS_DIGIT: if (in_word_q) tok_len_d = tok_len_inc;
      default: ;
    endcase
    if (term) begin
      if (id_count_q != '1)     id_count_d = id_count_q + CNT_W'(1);
      if (tok_len_q > max_len_q) max_len_d = tok_len_q;
      if (fifo_full && !fifo_pop) overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tok_len_q  <= '0;
      in_word_q  <= 1'b0;
      id_count_q <= '0;
      max_len_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      tok_len_q  <= tok_len_d;
      in_word_q  <= in_word_d;
      id_count_q <= id_count_d;
      max_len_q  <= max_len_d;
      overflow_q <= overflow_d;
    end
  end

  len_fifo #(
    .WIDTH (LEN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_len_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (term),
    .din   (tok_len_q),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign len_valid = !fifo_empty;
  assign len_data  = len_valid ? fifo_dout : '0;
  assign id_count  = id_count_q;
  assign max_len   = max_len_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_id_token_stat.sv
// tb/tb_id_token_stat.sv - directed self-checking bench for id_token_stat
module tb_id_token_stat;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  char_i;
  logic        id_match;
  logic        len_ready;

  logic        len_valid, overflow;
  logic [7:0]  len_data, max_len;
  logic [15:0] id_count;

  logic        s_len_valid, s_overflow;
  logic [2:0]  s_len_data, s_max_len;
  logic [1:0]  s_id_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_seen;

  // Upstream identifier FSM model: matches a letter-started run whose last char is a digit.
  bit m_word, m_dig;

  id_token_stat dut (
    .clk       (clk),
    .reset     (reset),
    .char_i    (char_i),
    .id_match  (id_match),
    .len_ready (len_ready),
    .len_valid (len_valid),
    .len_data  (len_data),
    .id_count  (id_count),
    .max_len   (max_len),
    .overflow  (overflow)
  );

  id_token_stat #(.CNT_W(2), .LEN_W(3), .FIFO_DEPTH(4)) dut_s (
    .clk       (clk),
    .reset     (reset),
    .char_i    (char_i),
    .id_match  (id_match),
    .len_ready (len_ready),
    .len_valid (s_len_valid),
    .len_data  (s_len_data),
    .id_count  (s_id_count),
    .max_len   (s_max_len),
    .overflow  (s_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send_raw(input logic [7:0] c, input logic m);
    char_i   = c;
    id_match = m;
    @(posedge clk);
    #1;
    if ((c >= 8'd65 && c <= 8'd90) || (c >= 8'd97 && c <= 8'd122)) begin
      m_word = 1'b1;
      m_dig  = 1'b0;
    end else if (c >= 8'd48 && c <= 8'd57) begin
      if (m_word) m_dig = 1'b1;
    end else begin
      m_word = 1'b0;
      m_dig  = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] c);
    send_raw(c, m_word && m_dig);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    m_word = 1'b0;
    m_dig  = 1'b0;
    #2;
    reset  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; char_i = 8'd32; id_match = 1'b0; len_ready = 1'b0;
    m_word = 1'b0; m_dig = 1'b0;
    #1;
    check("rst_valid",    len_valid, 0);
    check("rst_data",     len_data,  0);
    check("rst_count",    id_count,  0);
    check("rst_max",      max_len,   0);
    check("rst_overflow", overflow,  0);
    #12;
    reset = 1'b0;

    // "ab12 " with reader always ready
    len_ready = 1'b1;
    send_str("ab12");
    check("t1_pre_valid", len_valid, 0);
    send(" ");
    check("t1_valid", len_valid, 1);
    check("t1_data",  len_data,  4);
    check("t1_count", id_count,  1);
    check("t1_max",   max_len,   4);
    send(" ");
    check("t1_popped", len_valid, 0);
    check("t1_data0",  len_data,  0);

    // letter-ending token never pushes; leading digit excluded
    do_reset();
    send_str("abc;");
    check("t2_no_push", len_valid, 0);
    send_str("9x7;");
    check("t2_valid", len_valid, 1);
    check("t2_data",  len_data,  2);
    check("t2_count", id_count,  1);
    check("t2_max",   max_len,   2);

    // back-pressure: six tokens into a four-entry FIFO
    do_reset();
    len_ready = 1'b0;
    send_str("a1 ");
    check("t3_head_valid", len_valid, 1);
    check("t3_head_data",  len_data,  2);
    send_str("a1 a1 a1 ");
    check("t3_full_no_ovf", overflow, 0);
    send_str("a1 ");
    check("t3_ovf", overflow, 1);
    send_str("a1 ");
    check("t3_count", id_count, 6);
    check("t3_max",   max_len,  2);
    len_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_drain_valid%0d", i), len_valid, 1);
      check($sformatf("t3_drain_data%0d", i),  len_data,  2);
      send(" ");
    end
    check("t3_drained", len_valid, 0);
    check("t3_ovf_sticky", overflow, 1);

    // full FIFO: push and pop on the same edge
    do_reset();
    len_ready = 1'b0;
    send_str("a1 a1 a1 a1 ab1");
    len_ready = 1'b1;
    send(" ");
    len_ready = 1'b0;
    check("t4_no_ovf", overflow, 0);
    check("t4_count",  id_count, 5);
    check("t4_max",    max_len,  3);
    len_ready = 1'b1;
    n_seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (len_valid) n_seen++;
      send(" ");
    end
    check("t4_occupancy", n_seen, 4);

    // saturation on the narrow instance
    do_reset();
    len_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      send_str("abcdefghij1");
      send(" ");
      check($sformatf("t5_valid%0d", k), s_len_valid, 1);
      check($sformatf("t5_data%0d", k),  s_len_data,  7);
      check($sformatf("t5_count%0d", k), s_id_count,  (k < 3) ? k : 3);
    end
    check("t5_max", s_max_len,  7);
    check("t5_ovf", s_overflow, 0);

    // asynchronous reset mid-token clears everything without a clock edge
    do_reset();
    len_ready = 1'b0;
    send_str("x1 ");
    check("t6_pre_valid", len_valid, 1);
    send_str("ab1");
    #2;
    reset = 1'b1;
    #1;
    check("t6_async_valid", len_valid, 0);
    check("t6_async_data",  len_data,  0);
    check("t6_async_count", id_count,  0);
    check("t6_async_max",   max_len,   0);
    #1;
    reset = 1'b0;
    m_word = 1'b0;
    m_dig  = 1'b0;
    send_raw(8'd32, 1'b1);
    check("t6_no_push",  len_valid, 0);
    check("t6_count0",   id_count,  0);
    check("t6_ovf0",     overflow,  0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
